// File: rtl/uart_transceiver_param.sv
// uart_transceiver_param: full-duplex UART with configurable data width,
// stop bits and baud divisor, plus internal loopback and RX framing check.
// Optional feature macro: UART_PARITY_EN adds a parity bit after the data
// bits (even, or odd when PARITY_ODD=1) and drives parity_err.
module uart_transceiver_param #(
    parameter int CLKS_PER_BIT = 40,
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 send,
    input  logic [DATA_BITS-1:0] data_in,
    input  logic                 loopback,
    input  logic                 rx,
    output logic                 tx,
    output logic                 busy,
    output logic                 done,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 frame_err,
    output logic                 parity_err
);

`ifdef UART_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam int IW = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] BIT_END   = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_END  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [IW-1:0] LAST_BIT  = IW'(DATA_BITS - 1);
    localparam logic          STOP_LAST = (STOP_BITS == 2);
    localparam logic          ODD       = (PARITY_ODD != 0);

    // ---------------------------------------------------------------- TX
    typedef enum logic [2:0] {T_IDLE, T_START, T_DATA, T_PAR, T_STOP} tx_state_t;

    tx_state_t             tx_state, tx_state_n;
    logic [CW-1:0]         tx_cnt, tx_cnt_n;
    logic [IW-1:0]         tx_bit, tx_bit_n;
    logic                  tx_stop, tx_stop_n;
    logic [DATA_BITS-1:0]  tx_sh, tx_sh_n;
    logic                  tx_par, tx_par_n;
    logic                  tx_r, tx_n;
    logic                  send_q;
    logic                  tx_tick;

    assign tx   = tx_r;
    assign busy = (tx_state != T_IDLE);

    // TX next state: a send rising edge in IDLE starts a frame; each bit
    // holds for CLKS_PER_BIT cycles and tx is registered from tx_n.
    always_comb begin
        tx_state_n = tx_state;
        tx_cnt_n   = tx_cnt;
        tx_bit_n   = tx_bit;
        tx_stop_n  = tx_stop;
        tx_sh_n    = tx_sh;
        tx_par_n   = tx_par;
        tx_n       = tx_r;
        tx_tick    = (tx_cnt == BIT_END);
        if (tx_state != T_IDLE)
            tx_cnt_n = tx_tick ? '0 : tx_cnt + CW'(1);
        case (tx_state)
            T_IDLE: begin
                tx_n = 1'b1;
                if (send && !send_q) begin
                    tx_state_n = T_START;
                    tx_cnt_n   = '0;
                    tx_sh_n    = data_in;
                    tx_par_n   = (^data_in) ^ ODD;
                    tx_n       = 1'b0;
                end
            end
            T_START: if (tx_tick) begin
                tx_state_n = T_DATA;
                tx_bit_n   = '0;
                tx_n       = tx_sh[0];
            end
            T_DATA: if (tx_tick) begin
                if (tx_bit == LAST_BIT) begin
                    if (PAR_EN) begin
                        tx_state_n = T_PAR;
                        tx_n       = tx_par;
                    end else begin
                        tx_state_n = T_STOP;
                        tx_stop_n  = 1'b0;
                        tx_n       = 1'b1;
                    end
                end else begin
                    tx_bit_n = tx_bit + IW'(1);
                    tx_sh_n  = tx_sh >> 1;
                    tx_n     = tx_sh[1];
                end
            end
            T_PAR: if (tx_tick) begin
                tx_state_n = T_STOP;
                tx_stop_n  = 1'b0;
                tx_n       = 1'b1;
            end
            T_STOP: if (tx_tick) begin
                tx_n = 1'b1;
                if (tx_stop == STOP_LAST) tx_state_n = T_IDLE;
                else                      tx_stop_n  = 1'b1;
            end
            default: tx_state_n = T_IDLE;
        endcase
    end

    // TX state register; send_q remembers send for edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state <= T_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_stop  <= 1'b0;
            tx_sh    <= '0;
            tx_par   <= 1'b0;
            tx_r     <= 1'b1;
            send_q   <= 1'b0;
        end else begin
            tx_state <= tx_state_n;
            tx_cnt   <= tx_cnt_n;
            tx_bit   <= tx_bit_n;
            tx_stop  <= tx_stop_n;
            tx_sh    <= tx_sh_n;
            tx_par   <= tx_par_n;
            tx_r     <= tx_n;
            send_q   <= send;
        end
    end

    // ---------------------------------------------------------------- RX
    typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_PAR, R_STOP, R_WAIT} rx_state_t;

    rx_state_t             rx_state, rx_state_n;
    logic [CW-1:0]         rx_cnt, rx_cnt_n;
    logic [IW-1:0]         rx_bit, rx_bit_n;
    logic [DATA_BITS-1:0]  rx_sh, rx_sh_n;
    logic                  rx_pbit, rx_pbit_n;
    logic                  rx_s1, rx_s2, rx_prev;
    logic                  done_n, ferr_n, perr_n;
    logic [DATA_BITS-1:0]  dout_n;
    logic                  rx_tick;

    // Input select ahead of the synchronizer; rx_prev gives the falling edge
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= loopback ? tx_r : rx;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    // RX next state: half-bit start check, then mid-bit samples of the
    // data, optional parity and first stop bit
    always_comb begin
        rx_state_n = rx_state;
        rx_cnt_n   = rx_cnt + CW'(1);
        rx_bit_n   = rx_bit;
        rx_sh_n    = rx_sh;
        rx_pbit_n  = rx_pbit;
        dout_n     = data_out;
        done_n     = 1'b0;
        ferr_n     = 1'b0;
        perr_n     = 1'b0;
        rx_tick    = (rx_cnt == BIT_END);
        case (rx_state)
            R_IDLE: begin
                rx_cnt_n = '0;
                if (rx_prev && !rx_s2) rx_state_n = R_START;
            end
            R_START: if (rx_cnt == HALF_END) begin
                rx_cnt_n   = '0;
                rx_bit_n   = '0;
                rx_state_n = rx_s2 ? R_IDLE : R_DATA;
            end
            R_DATA: if (rx_tick) begin
                rx_cnt_n = '0;
                rx_sh_n  = {rx_s2, rx_sh[DATA_BITS-1:1]};
                if (rx_bit == LAST_BIT) rx_state_n = PAR_EN ? R_PAR : R_STOP;
                else                    rx_bit_n   = rx_bit + IW'(1);
            end
            R_PAR: if (rx_tick) begin
                rx_cnt_n   = '0;
                rx_pbit_n  = rx_s2;
                rx_state_n = R_STOP;
            end
            R_STOP: if (rx_tick) begin
                rx_cnt_n = '0;
                if (rx_s2) begin
                    done_n     = 1'b1;
                    dout_n     = rx_sh;
                    perr_n     = PAR_EN && (rx_pbit != ((^rx_sh) ^ ODD));
                    rx_state_n = R_IDLE;
                end else begin
                    ferr_n     = 1'b1;
                    rx_state_n = R_WAIT;
                end
            end
            R_WAIT: begin
                rx_cnt_n = '0;
                if (rx_s2) rx_state_n = R_IDLE;
            end
            default: rx_state_n = R_IDLE;
        endcase
    end

    // RX state register and registered result pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_state   <= R_IDLE;
            rx_cnt     <= '0;
            rx_bit     <= '0;
            rx_sh      <= '0;
            rx_pbit    <= 1'b0;
            data_out   <= '0;
            done       <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            rx_state   <= rx_state_n;
            rx_cnt     <= rx_cnt_n;
            rx_bit     <= rx_bit_n;
            rx_sh      <= rx_sh_n;
            rx_pbit    <= rx_pbit_n;
            data_out   <= dout_n;
            done       <= done_n;
            frame_err  <= ferr_n;
            parity_err <= perr_n;
        end
    end

endmodule
